// File: rtl/branch_resolve_queue_if.sv
// Fetch/execute-facing handshake bundle for branch_resolve_queue; slave is the queue itself.
// master drives push/resolve/flush, slave returns occupancy and the predictor update strobe.
interface branch_resolve_queue_if #(
  parameter int PCWIDTH   = 32,
  parameter int LOG2DEPTH = 2
);
  logic                 push;
  logic [PCWIDTH-1:0]   push_pc;
  logic                 push_pred;
  logic                 resolve;
  logic                 resolve_taken;
  logic                 flush;
  logic                 full;
  logic                 empty;
  logic [LOG2DEPTH:0]   count;
  logic                 result_rdy;
  logic [PCWIDTH-1:0]   pc_result;
  logic                 result;
  logic                 mispredict;

  modport master (
    output push, push_pc, push_pred, resolve, resolve_taken, flush,
    input  full, empty, count, result_rdy, pc_result, result, mispredict
  );

  modport slave (
    input  push, push_pc, push_pred, resolve, resolve_taken, flush,
    output full, empty, count, result_rdy, pc_result, result, mispredict
  );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches; retires head on resolve and emits a registered predictor update 1 cycle later.
// Full queue drops lone pushes (push+resolve still accepted); optional BRQ_STATS_EN adds update/mispredict counters.
module branch_resolve_queue #(
  parameter int PCWIDTH   = 32,
  parameter int DEPTH     = 4,
  parameter int LOG2DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  branch_resolve_queue_if.slave bus
`ifdef BRQ_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam logic [LOG2DEPTH:0]   CNT_FULL = (LOG2DEPTH+1)'(DEPTH);
  localparam logic [LOG2DEPTH:0]   CNT_ONE  = (LOG2DEPTH+1)'(1);
  localparam logic [LOG2DEPTH-1:0] PTR_ONE  = LOG2DEPTH'(1);

  // Each entry packs {pc, pred}; storage is deliberately left unreset.
  logic [PCWIDTH:0]     mem [DEPTH];
  logic [PCWIDTH:0]     head;
  logic [LOG2DEPTH-1:0] wr_ptr;
  logic [LOG2DEPTH-1:0] rd_ptr;
  logic [LOG2DEPTH:0]   cnt;
  logic                 is_full;
  logic                 is_empty;
  logic                 do_resolve;
  logic                 do_push;

  assign is_full  = (cnt == CNT_FULL);
  assign is_empty = (cnt == '0);
  assign head     = mem[rd_ptr];

  // Resolve only sees entries present before this edge, so no push->resolve bypass.
  assign do_resolve = bus.resolve && !bus.flush && !is_empty;
  assign do_push    = bus.push && !bus.flush && (!is_full || do_resolve);

  assign bus.full  = is_full;
  assign bus.empty = is_empty;
  assign bus.count = cnt;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= {bus.push_pc, bus.push_pred};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_resolve) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (do_push && !do_resolve) begin
        cnt <= cnt + CNT_ONE;
      end else if (do_resolve && !do_push) begin
        cnt <= cnt - CNT_ONE;
      end
    end
  end

  // pc_result/result hold their last update between strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.result_rdy <= 1'b0;
      bus.mispredict <= 1'b0;
      bus.pc_result  <= '0;
      bus.result     <= 1'b0;
    end else begin
      bus.result_rdy <= do_resolve;
      bus.mispredict <= do_resolve && (head[0] ^ bus.resolve_taken);
      if (do_resolve) begin
        bus.pc_result <= head[PCWIDTH:1];
        bus.result    <= bus.resolve_taken;
      end
    end
  end

`ifdef BRQ_STATS_EN
  // Counted from the registered strobe; flush deliberately leaves these alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (bus.result_rdy) begin
        stat_branches <= stat_branches + 32'd1;
      end
      if (bus.result_rdy && bus.mispredict) begin
        stat_mispredicts <= stat_mispredicts + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed test-plan scenarios followed by random traffic, all checked against a queue-based reference model.
module tb_branch_resolve_queue;
  localparam int PCW = 32;
  localparam int DEP = 4;
  localparam int L2D = 2;

  typedef struct {
    logic [PCW-1:0] pc;
    logic           pred;
  } ent_t;

  logic clk;
  logic reset;

  branch_resolve_queue_if #(.PCWIDTH(PCW), .LOG2DEPTH(L2D)) bus ();

`ifdef BRQ_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  branch_resolve_queue #(.PCWIDTH(PCW), .DEPTH(DEP), .LOG2DEPTH(L2D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef BRQ_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  ent_t           mq[$];
  logic           m_rdy;
  logic           m_mis;
  logic [PCW-1:0] m_pc;
  logic           m_res;
  logic [31:0]    m_sb;
  logic [31:0]    m_sm;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, advance the model with the same inputs, then compare after the edge.
  task automatic step(input logic rst, input logic p, input logic [PCW-1:0] pc, input logic pred,
                      input logic r, input logic taken, input logic fl);
    int   sz;
    bit   acc_r;
    bit   acc_p;
    ent_t h;
    reset             = rst;
    bus.push          = p;
    bus.push_pc       = pc;
    bus.push_pred     = pred;
    bus.resolve       = r;
    bus.resolve_taken = taken;
    bus.flush         = fl;
    @(posedge clk);
    sz    = mq.size();
    acc_r = r && !fl && (sz != 0);
    acc_p = p && !fl && ((sz < DEP) || acc_r);
    if (rst) begin
      mq.delete();
      m_rdy = 1'b0; m_mis = 1'b0; m_pc = '0; m_res = 1'b0;
      m_sb  = '0;   m_sm  = '0;
    end else begin
      if (m_rdy) m_sb = m_sb + 1;
      if (m_rdy && m_mis) m_sm = m_sm + 1;
      if (fl) begin
        mq.delete();
        m_rdy = 1'b0; m_mis = 1'b0;
      end else begin
        if (acc_r) begin
          h     = mq.pop_front();
          m_rdy = 1'b1;
          m_pc  = h.pc;
          m_res = taken;
          m_mis = h.pred ^ taken;
        end else begin
          m_rdy = 1'b0; m_mis = 1'b0;
        end
        if (acc_p) mq.push_back('{pc: pc, pred: pred});
      end
    end
    #1;
    chk("count",      64'(bus.count),      64'(mq.size()));
    chk("empty",      64'(bus.empty),      64'(mq.size() == 0));
    chk("full",       64'(bus.full),       64'(mq.size() == DEP));
    chk("result_rdy", 64'(bus.result_rdy), 64'(m_rdy));
    chk("mispredict", 64'(bus.mispredict), 64'(m_mis));
    chk("pc_result",  64'(bus.pc_result),  64'(m_pc));
    chk("result",     64'(bus.result),     64'(m_res));
`ifdef BRQ_STATS_EN
    chk("stat_branches",    64'(stat_branches),    64'(m_sb));
    chk("stat_mispredicts", 64'(stat_mispredicts), 64'(m_sm));
`endif
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push1(input logic [PCW-1:0] pc, input logic pred);
    step(1'b0, 1'b1, pc, pred, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic res1(input logic taken);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, taken, 1'b0);
  endtask

  initial begin
    m_rdy = 1'b0; m_mis = 1'b0; m_pc = '0; m_res = 1'b0; m_sb = '0; m_sm = '0;
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Single push/resolve, correct prediction.
    push1(32'h100, 1'b1);
    res1(1'b1);
    idle();

    // Two in-order mispredicts.
    push1(32'h200, 1'b0);
    push1(32'h204, 1'b1);
    res1(1'b1);
    res1(1'b0);
    idle();

    // Fill, drop a lone fifth push, then push+resolve while full and drain across the wrap.
    for (int i = 0; i < 4; i++) push1(32'h300 + 32'(4 * i), i[0]);
    push1(32'h3F0, 1'b1);
    step(1'b0, 1'b1, 32'h340, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) res1(i[1]);
    idle();

    // Resolve on empty, and resolve alongside a push into an empty queue.
    res1(1'b1);
    step(1'b0, 1'b1, 32'h400, 1'b0, 1'b1, 1'b1, 1'b0);
    res1(1'b1);
    idle();

    // Flush with simultaneous push/resolve, then a fresh pair.
    for (int i = 0; i < 3; i++) push1(32'h500 + 32'(4 * i), 1'b1);
    step(1'b0, 1'b1, 32'h5F0, 1'b1, 1'b1, 1'b1, 1'b1);
    idle();
    push1(32'h600, 1'b0);
    res1(1'b0);
    idle();

    // Reset mid-stream, one cycle after a resolve.
    for (int i = 0; i < 3; i++) push1(32'h700 + 32'(4 * i), 1'b0);
    res1(1'b1);
    step(1'b1, 1'b1, 32'h7F0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle();

    // Ten resolves with three mispredicts, then flush, then reset.
    for (int i = 0; i < 10; i++) begin
      push1(32'h800 + 32'(4 * i), 1'b1);
      res1((i % 4) != 1);
    end
    idle();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic           rr;
      logic           pp;
      logic           rs;
      logic           fl;
      logic [PCW-1:0] pc;
      rr = ($urandom_range(0, 199) == 0);
      pp = ($urandom_range(0, 9) < 6);
      rs = ($urandom_range(0, 9) < 5);
      fl = ($urandom_range(0, 39) == 0);
      pc = $urandom & 32'hFFFF_FFFC;
      step(rr, pp, pc, 1'($urandom), rs, 1'($urandom), fl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
